// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter guarded by `RETIRE_COUNT_EN.
module multicycle_control_fsm #(
    parameter int OPCODE_W = 7,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [1:0]          alu_op,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                pc_write,
    output logic                pc_source,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0]         retired
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I     = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_BR    = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);

    state_t cur;
    state_t nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    assign state = STATE_W'(cur);

    always_comb begin
        nxt        = cur;
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        illegal    = 1'b0;
        // Outputs are forced quiet while reset is held, even before the clock edge
        if (!rst) begin
            unique case (cur)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    if (opcode == OP_LOAD || opcode == OP_STORE) nxt = S_MEM_ADDR;
                    else if (opcode == OP_R)                     nxt = S_EXEC_R;
                    else if (opcode == OP_I)                     nxt = S_EXEC_I;
                    else if (opcode == OP_BR)                    nxt = S_BRANCH;
                    else if (opcode == OP_JAL)                   nxt = S_JAL;
                    else                                         nxt = S_ILLEGAL;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                    nxt       = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) nxt = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    nxt        = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) nxt = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                    nxt       = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                    nxt       = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    nxt       = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_source = 1'b1;
                    pc_write  = zero;
                    nxt       = S_FETCH;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                    nxt        = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
                end
                default: nxt = S_FETCH;
            endcase
        end
    end

`ifdef RETIRE_COUNT_EN
    logic retire;

    assign retire = (nxt == S_FETCH) &&
                    (cur == S_MEM_WB || cur == S_MEM_WR || cur == S_ALU_WB ||
                     cur == S_BRANCH || cur == S_JAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retired <= 32'd0;
        else if (retire) retired <= retired + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-instruction step lists
// push per-cycle expectations; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       pc_write;
        logic       pc_source;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic       illegal;
    } exp_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
    logic       pc_write, pc_source, ir_write, i_or_d;
    logic       mem_read, mem_write, reg_write, illegal;
    logic [3:0] state;
`ifdef RETIRE_COUNT_EN
    logic [31:0] retired;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int model_retired = 0;
    exp_t q[$];

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_source(pc_source),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write),
        .result_src(result_src), .illegal(illegal), .state(state)
`ifdef RETIRE_COUNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{state, alu_op, alu_src_a, alu_src_b, pc_write, pc_source,
                  ir_write, i_or_d, mem_read, mem_write, reg_write,
                  result_src, illegal};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cycle t=%0t: got %h expected %h (state got %0d expected %0d)",
                         $time, a, e, a.st, e.st);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: apply mem_ready, queue what the DUT must show this cycle
    task automatic cyc(input exp_t e, input logic rdy);
        mem_ready = rdy;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int stalls);
        exp_t e;
        e = '0;
        e.mem_read = 1'b1;
        e.src_b = 2'b01;
        repeat (stalls) cyc(e, 1'b0);
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        cyc(e, 1'b1);
        e = '0;
        e.st = 4'd1;
        e.src_a = 2'b01;
        e.src_b = 2'b10;
        cyc(e, rnd());
    endtask

    // zsel: 0 or 1 forces the zero flag in BRANCH, anything else randomizes it
    task automatic run_instr(input logic [6:0] op, input int sf, input int sm, input int zsel);
        exp_t e;
        opcode = op;
        fetch(sf);
        e = '0;
        if (op == OP_LOAD || op == OP_STORE) begin
            e.st = 4'd2; e.src_a = 2'b10; e.src_b = 2'b10;
            cyc(e, rnd());
            e = '0;
            e.i_or_d = 1'b1;
            if (op == OP_LOAD) begin
                e.st = 4'd3; e.mem_read = 1'b1;
            end else begin
                e.st = 4'd5; e.mem_write = 1'b1;
            end
            repeat (sm) cyc(e, 1'b0);
            cyc(e, 1'b1);
            if (op == OP_LOAD) begin
                e = '0;
                e.st = 4'd4; e.reg_write = 1'b1; e.result_src = 2'b01;
                cyc(e, rnd());
            end
        end else if (op == OP_R || op == OP_I) begin
            e.st = (op == OP_R) ? 4'd6 : 4'd7;
            e.src_a = 2'b10;
            e.src_b = (op == OP_R) ? 2'b00 : 2'b10;
            e.alu_op = (op == OP_R) ? 2'b10 : 2'b11;
            cyc(e, rnd());
            e = '0;
            e.st = 4'd8; e.reg_write = 1'b1;
            cyc(e, rnd());
        end else if (op == OP_BR) begin
            zero = (zsel == 0 || zsel == 1) ? 1'(zsel) : rnd();
            e.st = 4'd9; e.src_a = 2'b10; e.alu_op = 2'b01;
            e.pc_source = 1'b1; e.pc_write = zero;
            cyc(e, rnd());
        end else begin
            e.st = 4'd10; e.pc_write = 1'b1; e.pc_source = 1'b1;
            e.reg_write = 1'b1; e.result_src = 2'b10;
            cyc(e, rnd());
        end
        model_retired++;
    endtask

    // Assert rst between clock edges; outputs must drop at once
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_state", 32'(state), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        cyc('0, 1'b0);
        cyc('0, 1'b1);
        rst = 1'b0;
        model_retired = 0;
    endtask

    initial begin
        logic [6:0] ops [6];
        exp_t e;
        ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_R;
        ops[3] = OP_I;    ops[4] = OP_BR;    ops[5] = OP_JAL;

        chk("reset_state", 32'(state), 32'd0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_alu_src_b", 32'(alu_src_b), 32'd0);
        @(posedge clk);
        #1;
        cyc('0, 1'b1);
        rst = 1'b0;

        run_instr(OP_R, 0, 0, 2);
        run_instr(OP_LOAD, 0, 2, 2);
        run_instr(OP_BR, 0, 0, 1);
        run_instr(OP_BR, 0, 0, 0);
        run_instr(OP_I, 3, 0, 2);
        run_instr(OP_STORE, 1, 3, 2);
        run_instr(OP_JAL, 0, 0, 2);

        for (int i = 0; i < 40; i++)
            run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 2), 2);

        opcode = 7'b1111111;
        fetch(0);
        e = '0;
        e.st = 4'd11;
        e.illegal = 1'b1;
        repeat (10) cyc(e, rnd());
        do_reset();

        opcode = OP_STORE;
        fetch(0);
        e = '0;
        e.st = 4'd2; e.src_a = 2'b10; e.src_b = 2'b10;
        cyc(e, 1'b1);
        e = '0;
        e.st = 4'd5; e.mem_write = 1'b1; e.i_or_d = 1'b1;
        cyc(e, 1'b0);
        do_reset();

        repeat (3) run_instr(OP_I, 0, 0, 2);
`ifdef RETIRE_COUNT_EN
        chk("retired_count", retired, 32'(model_retired));
`endif
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
